dist_sampler: RTL and testbench
===============================

# dist_sampler

Measurement sequencer feeding the six-entry 13-bit distance RAM. On `start` it takes six consecutive ultrasonic readings (trigger pulse, echo-width measurement, conversion to centimetres). It writes each result into the RAM through a single write port, `ram_addr`/`ram_data`/`ram_we`. The RAM then presents all six values in parallel to the cube-positioning logic.

## Interface

Parameters:
- `TRIG_CYCLES`, default 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `TICK_CYCLES`, default 2941: echo-high clocks per centimetre (58.8 µs at 50 MHz).
- `WAIT_CYCLES`, default 1_500_000: maximum clocks between trigger end and echo rise.
- `GAP_CYCLES`, default 3_000_000: idle clocks between consecutive readings (60 ms).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `clear_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level; sampled in IDLE only, begins a 6-reading sweep.
- `echo`  in  1  asynchronous sensor echo; passed through a 2-flop synchronizer before use.
- `trigger`  out  1  sensor trigger pulse.
- `ram_we`  out  1  one-cycle write strobe to the RAM.
- `ram_addr`  out  3  RAM entry index, 0..5.
- `ram_data`  out  13  distance in cm, saturating at 8191.
- `busy`  out  1  high from sweep start until `done`.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `err`  out  6  per-entry timeout flags for the last sweep.

## Operation

- States: IDLE, TRIG, WAIT_ECHO, MEASURE, SETUP, WRITE, GAP, DONE.
- IDLE:
  - If `start`=1, clear `err`, set index=0, go to TRIG.
  - `start` is ignored in every other state.
- TRIG:
  - `trigger`=1 for exactly TRIG_CYCLES clocks, then go to WAIT_ECHO.
- WAIT_ECHO:
  - On synchronized echo rise, clear the tick and cm counters and go to MEASURE.
  - After WAIT_CYCLES clocks with no rise: set data=8191, set `err[index]`, go to SETUP.
- MEASURE:
  - The tick counter runs while echo=1. Each time it reaches TICK_CYCLES, cm increments (saturating at 8191) and the tick counter resets.
  - On echo fall, go to SETUP with data=cm. A partial tick is truncated.
  - If cm saturates while echo is still high, the block keeps waiting for the fall. It does not set `err`.
- SETUP:
  - One cycle. `ram_addr`=index and `ram_data` are stable, `ram_we`=0.
  - Required because the RAM registers its address only while its write enable is low.
- WRITE:
  - One cycle with `ram_we`=1; `ram_addr` and `ram_data` are unchanged.
  - If index=5, go to DONE. Otherwise index+1 and go to GAP.
- GAP:
  - Wait GAP_CYCLES clocks, then go to TRIG.
  - `ram_addr` presents the new index from GAP entry onward.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
  - `ram_data` and `err` hold their values until the next sweep.
- Index never exceeds 5; no wrap-around write occurs.
- `err` bits are set only by WAIT_ECHO timeout.

## Timing

- Reset (`clear_n`=0, any state, immediate):
  - `trigger`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `busy`=0, `done`=0, `err`=0.
  - State goes to IDLE and all counters clear.
  - A reset mid-sweep abandons the sweep. Entries already written stay in the RAM; they are cleared by the RAM's own clear.
- `busy` rises the cycle after `start` is sampled in IDLE, and falls in the same cycle `done` rises.
- Echo synchronizer adds 2 cycles of latency to both edges.
- Per-reading clock count = TRIG_CYCLES + echo-rise delay + echo width + sync latency + 2 (SETUP+WRITE), plus GAP_CYCLES between readings.
- Exactly six `ram_we` pulses per sweep, at addresses 0,1,2,3,4,5 in order. Each write is preceded by at least one cycle with `ram_we`=0 and the same `ram_addr`.
- `ram_we` is never high on two consecutive cycles.
- `trigger` and `ram_we` are never high simultaneously.

## Test plan

All scenarios use TRIG_CYCLES=4, TICK_CYCLES=10, WAIT_CYCLES=50, GAP_CYCLES=8.

- Reset mid-MEASURE: drop `clear_n` asynchronously, between clock edges -> all outputs 0 immediately; a later `start` begins again at address 0.
- Nominal sweep, echo widths 35, 100, 0-after-rise (1 cycle), 59, 10, 200 clocks:
  - -> writes of 3, 10, 0, 5, 1, 20 cm to addresses 0..5.
  - -> one `done` pulse, `err`=0.
  - -> each write preceded by a SETUP cycle at the same address.
- Timeout: no echo for entry 2 -> entry 2 written as 8191, `err`=6'b000100, other entries normal, sweep completes.
- Saturation: TICK_CYCLES=1 and echo high for 9000 clocks on entry 0 -> data 8191, `err[0]`=0.
- `start` pulsed repeatedly during a sweep -> no restart; exactly six writes; `busy` stays high until `done`.
- `trigger` width check: each trigger pulse is exactly 4 cycles, and there are exactly 6 pulses per sweep.

Source files
------------

// File: rtl/dist_sampler.sv
// Six-reading ultrasonic distance sweep: trigger, echo-width measurement, cm conversion,
// and a SETUP/WRITE handshake into the six-entry distance RAM.
module dist_sampler #(
   parameter int TRIG_CYCLES = 500,
   parameter int TICK_CYCLES = 2941,
   parameter int WAIT_CYCLES = 1_500_000,
   parameter int GAP_CYCLES  = 3_000_000
) (
   input  logic        clk,
   input  logic        clear_n,
   input  logic        start,
   input  logic        echo,
   output logic        trigger,
   output logic        ram_we,
   output logic [2:0]  ram_addr,
   output logic [12:0] ram_data,
   output logic        busy,
   output logic        done,
   output logic [5:0]  err
);

   typedef enum logic [2:0] {
      IDLE, TRIG, WAIT_ECHO, MEASURE, SETUP, WRITE, GAP, DONE
   } state_t;

   localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
   localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYCLES - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] TICK_N    = 32'(TICK_CYCLES);
   localparam logic [12:0] CM_MAX    = 13'h1FFF;
   localparam logic [2:0]  LAST_IDX  = 3'd5;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] tick_q, tick_d;
   logic [12:0] cm_q, cm_d;
   logic [2:0]  idx_q, idx_d;
   logic [12:0] data_q, data_d;
   logic [5:0]  err_q, err_d;
   logic        trig_q, trig_d;
   logic        we_q, we_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        sync1_q, sync2_q, echo_prev_q;

   logic        echo_rise;
   logic [31:0] tick_base, tick_inc, tick_step;
   logic [12:0] cm_base, cm_step;

   assign echo_rise = sync2_q & ~echo_prev_q;

   // The clock on which the rise is seen is itself the first echo-high tick,
   // so the step starts from zero outside MEASURE.
   always_comb begin
      tick_base = (state_q == MEASURE) ? tick_q : 32'd0;
      cm_base   = (state_q == MEASURE) ? cm_q : 13'd0;
      tick_inc  = tick_base + 32'd1;
      if (tick_inc >= TICK_N) begin
         tick_step = 32'd0;
         cm_step   = (cm_base == CM_MAX) ? cm_base : cm_base + 13'd1;
      end else begin
         tick_step = tick_inc;
         cm_step   = cm_base;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_d  = tick_q;
      cm_d    = cm_q;
      idx_d   = idx_q;
      data_d  = data_q;
      err_d   = err_q;
      trig_d  = trig_q;
      busy_d  = busy_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               err_d   = 6'd0;
               idx_d   = 3'd0;
               cnt_d   = 32'd0;
               trig_d  = 1'b1;
               busy_d  = 1'b1;
               state_d = TRIG;
            end
         end
         TRIG: begin
            if (cnt_q == TRIG_LAST) begin
               cnt_d   = 32'd0;
               trig_d  = 1'b0;
               state_d = WAIT_ECHO;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         WAIT_ECHO: begin
            if (echo_rise) begin
               tick_d  = tick_step;
               cm_d    = cm_step;
               state_d = MEASURE;
            end else if (cnt_q == WAIT_LAST) begin
               data_d        = CM_MAX;
               err_d[idx_q]  = 1'b1;
               state_d       = SETUP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         MEASURE: begin
            if (!sync2_q) begin
               data_d  = cm_q;
               state_d = SETUP;
            end else begin
               tick_d = tick_step;
               cm_d   = cm_step;
            end
         end
         SETUP: begin
            we_d    = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               cnt_d   = 32'd0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 32'd0;
               trig_d  = 1'b1;
               state_d = TRIG;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         tick_q      <= 32'd0;
         cm_q        <= 13'd0;
         idx_q       <= 3'd0;
         data_q      <= 13'd0;
         err_q       <= 6'd0;
         trig_q      <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         cm_q        <= cm_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         err_q       <= err_d;
         trig_q      <= trig_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sync1_q     <= echo;
         sync2_q     <= sync1_q;
         echo_prev_q <= sync2_q;
      end
   end

   assign trigger  = trig_q;
   assign ram_we   = we_q;
   assign ram_addr = idx_q;
   assign ram_data = data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dist_sampler.sv
// Directed bench for dist_sampler: reset, nominal sweep, mid-measure reset, timeout,
// ignored start pulses and cm saturation (second instance with one-clock ticks).
`timescale 1ns/1ps
module tb_dist_sampler;

   logic        clk = 1'b0;
   logic        clear_n, start, echo, start_s, echo_s;
   logic        trigger, ram_we, busy, done;
   logic [2:0]  ram_addr;
   logic [12:0] ram_data;
   logic [5:0]  err;
   logic        trigger_s, ram_we_s, busy_s, done_s;
   logic [2:0]  ram_addr_s;
   logic [12:0] ram_data_s;
   logic [5:0]  err_s;

   int tests_run = 0;
   int tests_failed = 0;

   // Write / trigger monitor state for the main instance.
   int          wr_n, setup_bad, we_bad, overlap_bad, done_cnt, busy_bad, trig_run;
   int          trig_w[$];
   logic [2:0]  wr_addr[8];
   logic [12:0] wr_data[8];
   logic        prev_we = 1'b0;
   logic [2:0]  prev_addr = 3'd0;
   logic        sweep_armed = 1'b0, busy_seen = 1'b0;
   logic [12:0] exp_q[$];
   int          w_tab[6];

   always #5 clk = ~clk;

   dist_sampler #(.TRIG_CYCLES(4), .TICK_CYCLES(10), .WAIT_CYCLES(50), .GAP_CYCLES(8)) dut (
      .clk(clk), .clear_n(clear_n), .start(start), .echo(echo), .trigger(trigger),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy),
      .done(done), .err(err)
   );

   dist_sampler #(.TRIG_CYCLES(4), .TICK_CYCLES(1), .WAIT_CYCLES(50), .GAP_CYCLES(8)) dut_sat (
      .clk(clk), .clear_n(clear_n), .start(start_s), .echo(echo_s), .trigger(trigger_s),
      .ram_we(ram_we_s), .ram_addr(ram_addr_s), .ram_data(ram_data_s), .busy(busy_s),
      .done(done_s), .err(err_s)
   );

   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         if (wr_n < 8) begin
            wr_addr[wr_n] = ram_addr;
            wr_data[wr_n] = ram_data;
         end
         wr_n++;
         if (prev_we !== 1'b0 || prev_addr !== ram_addr) setup_bad++;
         if (trigger === 1'b1) overlap_bad++;
         if (prev_we === 1'b1) we_bad++;
      end
      if (trigger === 1'b1) trig_run++;
      else if (trig_run > 0) begin
         trig_w.push_back(trig_run);
         trig_run = 0;
      end
      if (done === 1'b1) begin
         done_cnt++;
         if (busy !== 1'b0) busy_bad++;
         sweep_armed = 1'b0;
         busy_seen = 1'b0;
      end else if (sweep_armed) begin
         if (busy === 1'b1) busy_seen = 1'b1;
         else if (busy_seen) busy_bad++;
      end
      prev_we = ram_we;
      prev_addr = ram_addr;
   end

   task automatic clear_mon();
      wr_n = 0; setup_bad = 0; we_bad = 0; overlap_bad = 0;
      done_cnt = 0; busy_bad = 0; trig_run = 0;
      trig_w.delete();
      exp_q.delete();
   endtask

   task automatic begin_sweep();
      @(negedge clk);
      start = 1'b1;
      sweep_armed = 1'b1;
      busy_seen = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive_reading(input int idx, input int w);
      int n;
      n = 0;
      while (trigger !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin
         tests_run++; tests_failed++;
         $display("FAIL trig_rise[%0d]: trigger=%b, required 1", idx, trigger);
      end
      n = 0;
      while (trigger === 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         tests_run++; tests_failed++;
         $display("FAIL trig_fall[%0d]: trigger=%b, required 0", idx, trigger);
      end
      repeat (3) @(negedge clk);
      if (w > 0) begin
         echo = 1'b1;
         repeat (w) @(negedge clk);
         echo = 1'b0;
      end
      n = 0;
      while (wr_n < idx + 1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         tests_run++; tests_failed++;
         $display("FAIL write_wait[%0d]: writes=%0d, required %0d", idx, wr_n, idx + 1);
      end
   endtask

   task automatic drive_sweep();
      int n;
      for (int i = 0; i < 6; i++) drive_reading(i, w_tab[i]);
      n = 0;
      while (done_cnt < 1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         tests_run++; tests_failed++;
         $display("FAIL done_wait: done pulses=%0d, required 1", done_cnt);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      clear_n = 1'b0; start = 1'b0; echo = 1'b0; start_s = 1'b0; echo_s = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (trigger !== 1'b0) begin tests_failed++; $display("FAIL rst_trigger: got %b, required 0", trigger); end
      tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL rst_we: got %b, required 0", ram_we); end
      tests_run++; if (ram_addr !== 3'd0) begin tests_failed++; $display("FAIL rst_addr: got %0d, required 0", ram_addr); end
      tests_run++; if (ram_data !== 13'd0) begin tests_failed++; $display("FAIL rst_data: got %0d, required 0", ram_data); end
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_done: got %b%b, required 00", busy, done); end
      tests_run++; if (err !== 6'd0) begin tests_failed++; $display("FAIL rst_err: got %b, required 000000", err); end
      clear_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++; if (busy !== 1'b0 || trigger !== 1'b0) begin tests_failed++; $display("FAIL idle_hold: busy/trigger=%b%b, required 00", busy, trigger); end
   endtask

   task automatic test_nominal();
      logic [12:0] e;
      clear_mon();
      w_tab = '{35, 100, 1, 59, 10, 200};
      exp_q.push_back(13'd3); exp_q.push_back(13'd10); exp_q.push_back(13'd0);
      exp_q.push_back(13'd5); exp_q.push_back(13'd1); exp_q.push_back(13'd20);
      begin_sweep();
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL nom_busy_rise: got %b, required 1", busy); end
      drive_sweep();
      tests_run++; if (wr_n !== 6) begin tests_failed++; $display("FAIL nom_write_count: got %0d, required 6", wr_n); end
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         tests_run++; if (wr_addr[i] !== 3'(i)) begin tests_failed++; $display("FAIL nom_addr[%0d]: got %0d, required %0d", i, wr_addr[i], i); end
         tests_run++; if (wr_data[i] !== e) begin tests_failed++; $display("FAIL nom_data[%0d]: got %0d, required %0d", i, wr_data[i], e); end
      end
      tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL nom_done_count: got %0d, required 1", done_cnt); end
      tests_run++; if (err !== 6'd0) begin tests_failed++; $display("FAIL nom_err: got %b, required 000000", err); end
      tests_run++; if (setup_bad !== 0) begin tests_failed++; $display("FAIL nom_setup: bad writes %0d, required 0", setup_bad); end
      tests_run++; if (we_bad !== 0 || overlap_bad !== 0) begin tests_failed++; $display("FAIL nom_we_rules: b2b=%0d overlap=%0d, required 0 0", we_bad, overlap_bad); end
      tests_run++; if (busy_bad !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL nom_busy: bad=%0d busy=%b, required 0 0", busy_bad, busy); end
      tests_run++; if (trig_w.size() !== 6) begin tests_failed++; $display("FAIL nom_trig_count: got %0d, required 6", trig_w.size()); end
      foreach (trig_w[i]) begin
         tests_run++; if (trig_w[i] !== 4) begin tests_failed++; $display("FAIL nom_trig_width[%0d]: got %0d, required 4", i, trig_w[i]); end
      end
      tests_run++; if (ram_data !== 13'd20 || ram_addr !== 3'd5) begin tests_failed++; $display("FAIL nom_hold: data=%0d addr=%0d, required 20 5", ram_data, ram_addr); end
   endtask

   task automatic test_reset_mid_measure();
      int n;
      clear_mon();
      begin_sweep();
      drive_reading(0, 35);
      n = 0;
      while (trigger !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      while (trigger === 1'b1 && n < 150) begin @(negedge clk); n++; end
      if (n >= 150) begin tests_run++; tests_failed++; $display("FAIL mid_trig_wait: trigger=%b, required pulse", trigger); end
      repeat (3) @(negedge clk);
      echo = 1'b1;
      repeat (10) @(negedge clk);
      tests_run++; if (ram_addr !== 3'd1 || ram_data !== 13'd3 || busy !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: addr=%0d data=%0d busy=%b, required 1 3 1", ram_addr, ram_data, busy); end
      sweep_armed = 1'b0;
      @(posedge clk);
      #2 clear_n = 1'b0;
      #1;
      tests_run++; if (ram_addr !== 3'd0 || ram_data !== 13'd0) begin tests_failed++; $display("FAIL mid_rst_addr_data: addr=%0d data=%0d, required 0 0", ram_addr, ram_data); end
      tests_run++; if (busy !== 1'b0 || trigger !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0 || err !== 6'd0) begin tests_failed++; $display("FAIL mid_rst_ctrl: busy=%b trig=%b we=%b done=%b err=%b, required all 0", busy, trigger, ram_we, done, err); end
      echo = 1'b0;
      repeat (2) @(negedge clk);
      clear_n = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++; if (busy !== 1'b0 || trigger !== 1'b0) begin tests_failed++; $display("FAIL mid_no_resume: busy/trigger=%b%b, required 00", busy, trigger); end
   endtask

   task automatic test_timeout();
      logic [12:0] e;
      clear_mon();
      w_tab = '{35, 100, 0, 59, 10, 200};
      exp_q.push_back(13'd3); exp_q.push_back(13'd10); exp_q.push_back(13'd8191);
      exp_q.push_back(13'd5); exp_q.push_back(13'd1); exp_q.push_back(13'd20);
      begin_sweep();
      drive_sweep();
      tests_run++; if (wr_n !== 6) begin tests_failed++; $display("FAIL to_write_count: got %0d, required 6", wr_n); end
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         tests_run++; if (wr_addr[i] !== 3'(i) || wr_data[i] !== e) begin tests_failed++; $display("FAIL to_entry[%0d]: addr=%0d data=%0d, required %0d %0d", i, wr_addr[i], wr_data[i], i, e); end
      end
      tests_run++; if (err !== 6'b000100) begin tests_failed++; $display("FAIL to_err: got %b, required 000100", err); end
      tests_run++; if (done_cnt !== 1 || setup_bad !== 0) begin tests_failed++; $display("FAIL to_done_setup: done=%0d setup_bad=%0d, required 1 0", done_cnt, setup_bad); end
   endtask

   task automatic test_start_ignored();
      clear_mon();
      w_tab = '{10, 10, 10, 10, 10, 10};
      begin_sweep();
      fork
         drive_sweep();
         begin
            for (int k = 0; k < 60; k++) begin
               if (done_cnt > 0 || busy !== 1'b1) break;
               @(negedge clk); start = 1'b1;
               @(negedge clk); start = 1'b0;
            end
         end
      join
      start = 1'b0;
      repeat (20) @(negedge clk);
      tests_run++; if (wr_n !== 6) begin tests_failed++; $display("FAIL si_write_count: got %0d, required 6", wr_n); end
      for (int i = 0; i < 6; i++) begin
         tests_run++; if (wr_addr[i] !== 3'(i) || wr_data[i] !== 13'd1) begin tests_failed++; $display("FAIL si_entry[%0d]: addr=%0d data=%0d, required %0d 1", i, wr_addr[i], wr_data[i], i); end
      end
      tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL si_done_count: got %0d, required 1", done_cnt); end
      tests_run++; if (busy_bad !== 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL si_busy: bad=%0d busy=%b, required 0 0", busy_bad, busy); end
      tests_run++; if (trig_w.size() !== 6) begin tests_failed++; $display("FAIL si_trig_count: got %0d, required 6", trig_w.size()); end
   endtask

   task automatic test_saturation();
      int n;
      int w;
      logic [12:0] e;
      @(negedge clk); start_s = 1'b1;
      @(negedge clk); start_s = 1'b0;
      for (int i = 0; i < 6; i++) begin
         w = (i == 0) ? 9000 : 5;
         e = (i == 0) ? 13'd8191 : 13'd5;
         n = 0;
         while (trigger_s !== 1'b1 && n < 100) begin @(negedge clk); n++; end
         while (trigger_s === 1'b1 && n < 150) begin @(negedge clk); n++; end
         if (n >= 150) begin tests_run++; tests_failed++; $display("FAIL sat_trig_wait[%0d]: trigger=%b, required pulse", i, trigger_s); end
         repeat (3) @(negedge clk);
         echo_s = 1'b1;
         repeat (w) @(negedge clk);
         echo_s = 1'b0;
         n = 0;
         while (ram_we_s !== 1'b1 && n < 100) begin @(negedge clk); n++; end
         tests_run++; if (ram_we_s !== 1'b1 || ram_addr_s !== 3'(i) || ram_data_s !== e) begin tests_failed++; $display("FAIL sat_entry[%0d]: we=%b addr=%0d data=%0d, required 1 %0d %0d", i, ram_we_s, ram_addr_s, ram_data_s, i, e); end
         @(negedge clk);
      end
      n = 0;
      while (done_s !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      tests_run++; if (done_s !== 1'b1) begin tests_failed++; $display("FAIL sat_done: got %b, required 1", done_s); end
      tests_run++; if (err_s !== 6'd0) begin tests_failed++; $display("FAIL sat_err: got %b, required 000000", err_s); end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_mon();
      test_reset();
      test_nominal();
      test_reset_mid_measure();
      test_timeout();
      test_start_ignored();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
